// File: rtl/ay_input_conditioner_if.sv
// Pin bundle between the board's raw switches/buttons and the game chip.
// The master side owns the raw inputs, the slave side (conditioner) owns the outputs.
interface ay_input_conditioner_if;
    logic [3:0] sw_n;
    logic [5:0] game_btn_n;
    logic       reset_btn_n;
    logic [3:0] sw_db_n;
    logic [5:0] game_n;
    logic       chip_reset_n;

    modport master (
        output sw_n, game_btn_n, reset_btn_n,
        input  sw_db_n, game_n, chip_reset_n
    );

    modport slave (
        input  sw_n, game_btn_n, reset_btn_n,
        output sw_db_n, game_n, chip_reset_n
    );
endinterface

// File: rtl/ay_input_conditioner.sv
// Synchronizes and debounces the AY game-chip switches/buttons, selects the game and
// generates the chip reset pulse. Define GAME_LATCH_EN for latched push-button game select.
module ay_input_conditioner #(
    parameter int DEBOUNCE_CYCLES    = 160000,
    parameter int RESET_PULSE_CYCLES = 1600
) (
    input logic                  CLK,
    input logic                  reset_n,
    ay_input_conditioner_if.slave io
);
    localparam int NIN = 11;
    localparam int CW  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int PW  = $clog2(RESET_PULSE_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic [PW-1:0] PULSE_LOAD  = PW'(RESET_PULSE_CYCLES);
    localparam logic [5:0]    GAME_TENNIS = 6'b110111;

    // Input bit map: [3:0] switches, [9:4] game buttons, [10] reset button.
    logic [NIN-1:0]         raw;
    logic [NIN-1:0]         sync1_q, sync2_q;
    logic [NIN-1:0]         db_q, db_d;
    logic [NIN-1:0][CW-1:0] cnt_q, cnt_d;
    logic [5:0]             game_n_q, game_n_d;
    logic [PW-1:0]          pulse_q, pulse_d;
    logic                   chip_reset_n_q, chip_reset_n_d;
    logic                   rbtn_rise;

`ifdef GAME_LATCH_EN
    logic [5:0] game_prev_q;
    logic [5:0] game_fall;
    logic [2:0] sel;
    logic       sel_valid;
`endif

    assign raw = {io.reset_btn_n, io.game_btn_n, io.sw_n};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < NIN; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = sync2_q[i];
                end else if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end
        end
    end

    // Rising edge taken on the update itself so the pulse starts as the button releases.
    assign rbtn_rise = ~db_q[10] & db_d[10];

`ifdef GAME_LATCH_EN
    assign game_fall = game_prev_q & ~db_q[9:4];
`endif

    always_comb begin
        game_n_d = game_n_q;
        pulse_d  = pulse_q;
        if (pulse_q != '0) begin
            pulse_d = pulse_q - 1'b1;
        end
`ifdef GAME_LATCH_EN
        sel       = '0;
        sel_valid = 1'b0;
        // Descending scan so the lowest pressed index is the one left in sel.
        for (int i = 5; i >= 0; i--) begin
            if (game_fall[i]) begin
                sel       = 3'(i);
                sel_valid = 1'b1;
            end
        end
        if (sel_valid && game_n_q[sel]) begin
            game_n_d = ~(6'b000001 << sel);
            pulse_d  = PULSE_LOAD;
        end
`else
        game_n_d = db_q[9:4];
`endif
        if (rbtn_rise) begin
            pulse_d = PULSE_LOAD;
        end
        chip_reset_n_d = (pulse_d == '0) && db_d[10];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q        <= '1;
            sync2_q        <= '1;
            db_q           <= '1;
            cnt_q          <= '0;
            game_n_q       <= GAME_TENNIS;
            pulse_q        <= PULSE_LOAD;
            chip_reset_n_q <= 1'b0;
`ifdef GAME_LATCH_EN
            game_prev_q    <= '1;
`endif
        end else begin
            sync1_q        <= raw;
            sync2_q        <= sync1_q;
            db_q           <= db_d;
            cnt_q          <= cnt_d;
            game_n_q       <= game_n_d;
            pulse_q        <= pulse_d;
            chip_reset_n_q <= chip_reset_n_d;
`ifdef GAME_LATCH_EN
            game_prev_q    <= db_q[9:4];
`endif
        end
    end

    assign io.sw_db_n      = db_q[3:0];
    assign io.game_n       = game_n_q;
    assign io.chip_reset_n = chip_reset_n_q;
endmodule

// File: tb/tb_ay_input_conditioner.sv
// Self-checking bench for ay_input_conditioner (DEBOUNCE_CYCLES=8, RESET_PULSE_CYCLES=4);
// compile with +define+GAME_LATCH_EN to exercise the latched game select.
module tb_ay_input_conditioner;
    localparam int N = 8;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    ay_input_conditioner_if io();

    ay_input_conditioner #(
        .DEBOUNCE_CYCLES   (N),
        .RESET_PULSE_CYCLES(P)
    ) dut (
        .CLK    (clk),
        .reset_n(rst_n),
        .io     (io)
    );

    always #5 clk = ~clk;

    // Reference model state: pin history, debounced view, game, pulse end time.
    logic [10:0] hist[$];
    logic [10:0] m_db;
    logic [5:0]  m_game;
    logic [5:0]  m_pend;
    logic        m_chip;
    int          m_k;
    int          m_pulse_end;

    typedef struct {
        logic [3:0] sw;
        logic [5:0] game;
        logic       rbtn;
        int         cycles;
        logic [3:0] exp_sw;
        logic [5:0] exp_game;
        logic       exp_chip;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < N + 2; i++) hist.push_back(11'h7ff);
        m_db        = '1;
        m_game      = 6'b110111;
        m_pend      = '0;
        m_chip      = 1'b0;
        m_k         = 0;
        m_pulse_end = P;
    endtask

    // A debounced bit flips once its last N synchronized samples all disagree with it;
    // the synchronized sample seen at edge k is the pin sampled two edges earlier.
    task automatic model_edge();
        logic [10:0] p;
        logic [10:0] old_db;
        logic [10:0] nd;
        logic        all_diff;
        p = {io.reset_btn_n, io.game_btn_n, io.sw_n};
        hist.push_front(p);
        m_k++;
        old_db = m_db;
        nd     = m_db;
        for (int b = 0; b < 11; b++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= N + 1; j++) begin
                if (hist[j][b] == old_db[b]) all_diff = 1'b0;
            end
            if (all_diff) nd[b] = ~old_db[b];
        end
        void'(hist.pop_back());
`ifdef GAME_LATCH_EN
        if (m_pend != '0) begin
            int lo;
            lo = -1;
            for (int i = 5; i >= 0; i--) if (m_pend[i]) lo = i;
            if (m_game[lo]) begin
                m_game      = ~(6'b000001 << lo);
                m_pulse_end = m_k + P;
            end
        end
        m_pend = old_db[9:4] & ~nd[9:4];
`else
        m_game = old_db[9:4];
`endif
        if (!old_db[10] && nd[10]) m_pulse_end = m_k + P;
        m_chip = (m_k >= m_pulse_end) && nd[10];
        m_db   = nd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model sw_db_n", io.sw_db_n, m_db[3:0]);
        check("model game_n", io.game_n, m_game);
        check("model chip_reset_n", io.chip_reset_n, m_chip);
    endtask

    task automatic set_pins(input logic [3:0] sw, input logic [5:0] game, input logic rbtn);
        io.sw_n        = sw;
        io.game_btn_n  = game;
        io.reset_btn_n = rbtn;
    endtask

    task automatic idle(input int n);
        set_pins(4'hf, 6'h3f, 1'b1);
        repeat (n) tick();
    endtask

    initial begin
        int          first;
        logic        bad;
        logic [10:0] p;

        rst_n = 1'b0;
        set_pins(4'hf, 6'h3f, 1'b1);
        model_reset();
        #12;
        check("reset sw_db_n", io.sw_db_n, 4'b1111);
        check("reset game_n", io.game_n, 6'b110111);
        check("reset chip_reset_n", io.chip_reset_n, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Power-on pulse: low for exactly P cycles after release.
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (first == 0 && io.chip_reset_n === 1'b1) first = i;
        end
        check("power-on pulse length", first, P);
        check("post-reset game_n", io.game_n,
`ifdef GAME_LATCH_EN
              6'b110111);
`else
              6'b111111);
`endif
        check("post-reset sw_db_n", io.sw_db_n, 4'b1111);

        // Short glitch is filtered, held level arrives N+2 cycles after the pin.
        set_pins(4'b1011, 6'h3f, 1'b1);
        repeat (5) tick();
        set_pins(4'hf, 6'h3f, 1'b1);
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (io.sw_db_n !== 4'b1111) bad = 1'b1;
        end
        check("glitch filtered", bad, 1'b0);
        set_pins(4'b1011, 6'h3f, 1'b1);
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (first == 0 && io.sw_db_n[2] === 1'b0) first = i;
        end
        check("sw debounce latency", first, N + 2);
        idle(16);

`ifdef GAME_LATCH_EN
        // Soccer press: latched one cycle after the debounced edge, pulse P cycles.
        set_pins(4'hf, 6'b111011, 1'b1);
        repeat (10) tick();
        check("soccer before edge", io.game_n, 6'b110111);
        tick();
        check("soccer selected", io.game_n, 6'b111011);
        check("soccer pulse start", io.chip_reset_n, 1'b0);
        repeat (3) tick();
        check("soccer pulse end-1", io.chip_reset_n, 1'b0);
        tick();
        check("soccer pulse done", io.chip_reset_n, 1'b1);
        repeat (5) tick();
        idle(20);
        check("soccer kept after release", io.game_n, 6'b111011);

        // Simultaneous rifle1 + squash: lowest index wins; repeat squash is a no-op.
        set_pins(4'hf, 6'b101101, 1'b1);
        repeat (11) tick();
        check("squash wins", io.game_n, 6'b111101);
        idle(16);
        set_pins(4'hf, 6'b111101, 1'b1);
        bad = 1'b0;
        repeat (16) begin
            tick();
            if (io.chip_reset_n !== 1'b1 || io.game_n !== 6'b111101) bad = 1'b1;
        end
        check("reselect no pulse", bad, 1'b0);
        idle(16);
`else
        // Rotary wiring: game_n follows the debounced buttons one register later.
        set_pins(4'hf, 6'b101111, 1'b1);
        bad = 1'b0;
        repeat (10) begin
            tick();
            if (io.chip_reset_n !== 1'b1) bad = 1'b1;
        end
        check("rotary before", io.game_n, 6'b111111);
        tick();
        check("rotary after 11", io.game_n, 6'b101111);
        repeat (5) begin
            tick();
            if (io.chip_reset_n !== 1'b1) bad = 1'b1;
        end
        check("rotary no pulse", bad, 1'b0);
        idle(16);
`endif

        // Reset button hold, then full pulse after the debounced release.
        set_pins(4'hf, 6'h3f, 1'b0);
        first = 0;
        bad   = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (first == 0 && io.chip_reset_n === 1'b0) first = i;
            if (first != 0 && io.chip_reset_n !== 1'b0) bad = 1'b1;
        end
        check("reset button assert latency", first, N + 2);
        check("reset button held low", bad, 1'b0);
        set_pins(4'hf, 6'h3f, 1'b1);
        first = 0;
        for (int i = 1; i <= 30; i++) begin
`ifdef GAME_LATCH_EN
            if (i == 2) io.game_btn_n = 6'b111110;
`endif
            tick();
            if (first == 0 && io.chip_reset_n === 1'b1) first = i;
        end
`ifdef GAME_LATCH_EN
        check("pulse extended by game change", first, N + 2 + 2 + P);
        check("practice selected", io.game_n, 6'b111110);
`else
        check("reset button release pulse", first, N + 2 + P);
`endif
        idle(16);

`ifdef GAME_LATCH_EN
        tbl[0] = '{4'b1010, 6'b011111, 1'b1, 16, 4'b1010, 6'b011111, 1'b1};
        tbl[1] = '{4'b0101, 6'b111111, 1'b1, 16, 4'b0101, 6'b011111, 1'b1};
        tbl[2] = '{4'b0000, 6'b111110, 1'b1, 16, 4'b0000, 6'b111110, 1'b1};
        tbl[3] = '{4'b1111, 6'b111111, 1'b0, 16, 4'b1111, 6'b111110, 1'b0};
        tbl[4] = '{4'b0110, 6'b110111, 1'b1, 16, 4'b0110, 6'b110111, 1'b1};
        tbl[5] = '{4'b1111, 6'b111111, 1'b1, 16, 4'b1111, 6'b110111, 1'b1};
`else
        tbl[0] = '{4'b1010, 6'b111110, 1'b1, 12, 4'b1010, 6'b111110, 1'b1};
        tbl[1] = '{4'b0101, 6'b011111, 1'b1, 12, 4'b0101, 6'b011111, 1'b1};
        tbl[2] = '{4'b0000, 6'b111111, 1'b0, 12, 4'b0000, 6'b111111, 1'b0};
        tbl[3] = '{4'b1111, 6'b111111, 1'b1, 16, 4'b1111, 6'b111111, 1'b1};
        tbl[4] = '{4'b0110, 6'b110111, 1'b1, 12, 4'b0110, 6'b110111, 1'b1};
        tbl[5] = '{4'b1111, 6'b111111, 1'b1, 12, 4'b1111, 6'b111111, 1'b1};
`endif
        for (int v = 0; v < 6; v++) begin
            set_pins(tbl[v].sw, tbl[v].game, tbl[v].rbtn);
            repeat (tbl[v].cycles) tick();
            check($sformatf("table[%0d] sw_db_n", v), io.sw_db_n, tbl[v].exp_sw);
            check($sformatf("table[%0d] game_n", v), io.game_n, tbl[v].exp_game);
            check($sformatf("table[%0d] chip_reset_n", v), io.chip_reset_n, tbl[v].exp_chip);
        end

        // Random bouncing inputs against the reference model.
        p = 11'h7ff;
        repeat (600) begin
            for (int b = 0; b < 11; b++) begin
                if ($urandom_range(9) == 0) p[b] = ~p[b];
            end
            set_pins(p[3:0], p[9:4], p[10]);
            tick();
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
